// File: rtl/frame_axis_tx.sv
// Test-pattern frame source on an AXI-Stream style master port.
// Emits HEIGHT lines of WIDTH pixels with H_GAP idle cycles between lines.
module frame_axis_tx #(
    parameter int unsigned WIDTH      = 800,
    parameter int unsigned HEIGHT     = 600,
    parameter int unsigned BIT_DATA_O = 8,
    parameter int unsigned H_GAP      = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  start_i,
    input  logic                  cont_i,
    input  logic [1:0]            mode_i,
    input  logic [BIT_DATA_O-1:0] const_i,
    input  logic                  tready_i,
    output logic [BIT_DATA_O-1:0] tdata_o,
    output logic                  tvalid_o,
    output logic                  tlast_o,
    output logic                  tuser_o,
    output logic                  busy_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int unsigned XW       = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
    localparam int unsigned YW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned GW       = (H_GAP > 1)  ? $clog2(H_GAP)  : 1;
    localparam int unsigned GAP_LOAD = (H_GAP > 0)  ? H_GAP - 1      : 0;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [1:0]            mode_q, mode_d;
    logic [BIT_DATA_O-1:0] const_q, const_d;
    logic [15:0]           cnt_d;

    logic                  valid_d;
    logic                  user_d;
    logic                  last_d;
    logic                  busy_d;
    logic [BIT_DATA_O-1:0] data_d;

    // Next-state, counters and the registered-output values they imply
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        gap_d   = gap_q;
        mode_d  = mode_q;
        const_d = const_q;
        cnt_d   = frame_cnt_o;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    mode_d  = mode_i;
                    const_d = const_i;
                end
            end
            ACTIVE: begin
                if (tready_i) begin
                    if (x_q != X_LAST) begin
                        x_d = x_q + XW'(1);
                    end else if (y_q != Y_LAST) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                        if (H_GAP > 0) begin
                            state_d = GAP;
                            gap_d   = GW'(GAP_LOAD);
                        end
                    end else begin
                        cnt_d = frame_cnt_o + 16'd1;
                        x_d   = '0;
                        y_d   = '0;
                        if (cont_i) begin
                            mode_d  = mode_i;
                            const_d = const_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = ACTIVE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == ACTIVE);
        busy_d  = (state_d != IDLE);
        user_d  = valid_d && (x_d == '0) && (y_d == '0);
        last_d  = valid_d && (x_d == X_LAST) && (y_d == Y_LAST);

        data_d = '0;
        if (valid_d) begin
            case (mode_d)
                2'd0:    data_d = BIT_DATA_O'(x_d);
                2'd1:    data_d = BIT_DATA_O'(y_d);
                2'd2:    data_d = BIT_DATA_O'(x_d) + BIT_DATA_O'(y_d);
                default: data_d = const_d;
            endcase
        end
    end

    // State, counters and output registers
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            gap_q       <= '0;
            mode_q      <= '0;
            const_q     <= '0;
            frame_cnt_o <= '0;
            tvalid_o    <= 1'b0;
            tuser_o     <= 1'b0;
            tlast_o     <= 1'b0;
            busy_o      <= 1'b0;
            tdata_o     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            gap_q       <= gap_d;
            mode_q      <= mode_d;
            const_q     <= const_d;
            frame_cnt_o <= cnt_d;
            tvalid_o    <= valid_d;
            tuser_o     <= user_d;
            tlast_o     <= last_d;
            busy_o      <= busy_d;
            tdata_o     <= data_d;
        end
    end

endmodule

// File: tb/tb_frame_axis_tx.sv
// Self-checking bench for frame_axis_tx: table of frame scenarios, hand sequences
// for reset/wrap, random frames, all checked against a beat-queue reference model.
module tb_frame_axis_tx;

    localparam int unsigned W = 4;
    localparam int unsigned H = 3;
    localparam int unsigned G = 2;
    localparam int unsigned D = 8;

    logic         clk_i = 1'b0;
    logic         arst_i = 1'b1;
    logic         start_i = 1'b0;
    logic         cont_i = 1'b0;
    logic [1:0]   mode_i = 2'd0;
    logic [D-1:0] const_i = '0;
    logic         tready_i = 1'b0;
    logic [D-1:0] tdata_o;
    logic         tvalid_o;
    logic         tlast_o;
    logic         tuser_o;
    logic         busy_o;
    logic [15:0]  frame_cnt_o;

    frame_axis_tx #(.WIDTH(W), .HEIGHT(H), .BIT_DATA_O(D), .H_GAP(G)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .start_i     (start_i),
        .cont_i      (cont_i),
        .mode_i      (mode_i),
        .const_i     (const_i),
        .tready_i    (tready_i),
        .tdata_o     (tdata_o),
        .tvalid_o    (tvalid_o),
        .tlast_o     (tlast_o),
        .tuser_o     (tuser_o),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [D-1:0] data;
        logic         user;
        logic         last;
        int           gap;
    } beat_t;

    typedef struct {
        logic [1:0]   mode;
        logic [D-1:0] konst;
        int           rdy;
        int           nfr;
        logic [D-1:0] first_d;
        logic [D-1:0] last_d;
    } vec_t;

    beat_t        exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_xfer = 0;
    int           idle_run = 0;
    bit           presented = 1'b0;
    bit           prev_stall = 1'b0;
    logic [D-1:0] prev_data = '0;
    logic [D-1:0] first_data = '0;
    logic [D-1:0] last_data = '0;
    logic [15:0]  exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is just HEIGHT x WIDTH beats with pattern data in raster order
    task automatic push_frame(input logic [1:0] m, input logic [D-1:0] k, input int first_gap);
        beat_t b;
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                case (m)
                    2'd0:    b.data = D'(x);
                    2'd1:    b.data = D'(y);
                    2'd2:    b.data = D'((x + y) % 256);
                    default: b.data = k;
                endcase
                b.user = (x == 0) && (y == 0);
                b.last = (x == int'(W) - 1) && (y == int'(H) - 1);
                if (x == 0 && y == 0)  b.gap = first_gap;
                else if (x == 0)       b.gap = int'(G);
                else                   b.gap = 0;
                exp_q.push_back(b);
            end
        end
    endtask

    // Observe the current cycle (inputs already driven), then advance one clock
    task automatic cycle();
        beat_t e;
        if (!tvalid_o) chk("idle_zero", 32'({tdata_o, tuser_o, tlast_o}), 32'd0);
        if (prev_stall) begin
            chk("stall_valid", 32'(tvalid_o), 32'd1);
            chk("stall_data", 32'(tdata_o), 32'(prev_data));
        end
        if (tvalid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_beat: got data 0x%0h, expected no beat at %0t", tdata_o, $time);
            end else begin
                if (!presented) begin
                    presented = 1'b1;
                    if (exp_q[0].gap >= 0) chk("line_gap", 32'(idle_run), 32'(exp_q[0].gap));
                end
                if (tready_i) begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(tdata_o), 32'(e.data));
                    chk("beat_user", 32'(tuser_o), 32'(e.user));
                    chk("beat_last", 32'(tlast_o), 32'(e.last));
                    if (n_xfer == 0) first_data = tdata_o;
                    last_data = tdata_o;
                    n_xfer++;
                    presented = 1'b0;
                end
            end
            idle_run = 0;
        end else begin
            idle_run++;
        end
        prev_stall = tvalid_o && !tready_i;
        prev_data  = tdata_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_frames(input logic [1:0] m, input logic [D-1:0] k, input int rdy,
                              input int nfr, input bit hold_start, input bit scramble);
        int budget;
        n_xfer  = 0;
        mode_i  = m;
        const_i = k;
        cont_i  = (nfr > 1);
        start_i = 1'b1;
        for (int f = 0; f < nfr; f++) push_frame(m, k, (f == 0) ? -1 : 0);
        tready_i = 1'b0;
        cycle();
        if (!hold_start) start_i = 1'b0;
        budget = 400;
        while ((busy_o || exp_q.size() != 0) && budget > 0) begin
            case (rdy)
                0:       tready_i = 1'b1;
                1:       tready_i = ~tready_i;
                default: tready_i = ($urandom % 4) != 0;
            endcase
            cont_i = (exp_q.size() > int'(W * H));
            if (hold_start && exp_q.size() <= 1) start_i = 1'b0;
            if (scramble) begin
                mode_i  = 2'($urandom);
                const_i = D'($urandom);
            end
            cycle();
            budget--;
        end
        start_i = 1'b0;
        cont_i  = 1'b0;
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d beats left, expected 0", exp_q.size());
            exp_q.delete();
        end
        exp_cnt = exp_cnt + 16'(nfr);
        chk("xfer_count", 32'(n_xfer), 32'(nfr * int'(W * H)));
        chk("frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
        chk("idle_after", 32'(busy_o), 32'd0);
        repeat (3) cycle();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{mode: 2'd2, konst: 8'h00, rdy: 0, nfr: 1, first_d: 8'd0,  last_d: 8'd5};
        vecs[1] = '{mode: 2'd3, konst: 8'hA5, rdy: 1, nfr: 1, first_d: 8'hA5, last_d: 8'hA5};
        vecs[2] = '{mode: 2'd0, konst: 8'h00, rdy: 0, nfr: 2, first_d: 8'd0,  last_d: 8'd3};
        vecs[3] = '{mode: 2'd1, konst: 8'h3C, rdy: 2, nfr: 1, first_d: 8'd0,  last_d: 8'd2};
        vecs[4] = '{mode: 2'd2, konst: 8'h77, rdy: 2, nfr: 1, first_d: 8'd0,  last_d: 8'd5};

        #2;
        chk("reset_outputs", 32'({tdata_o, tvalid_o, tuser_o, tlast_o, busy_o}), 32'd0);
        chk("reset_cnt", 32'(frame_cnt_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        repeat (2) cycle();

        for (int i = 0; i < 5; i++) begin
            run_frames(vecs[i].mode, vecs[i].konst, vecs[i].rdy, vecs[i].nfr, 1'b0, 1'b0);
            chk("first_data", 32'(first_data), 32'(vecs[i].first_d));
            chk("last_data", 32'(last_data), 32'(vecs[i].last_d));
        end

        // start held high and mode/const scrambled mid-frame: frame keeps its latched pattern
        run_frames(2'd2, 8'h11, 0, 1, 1'b1, 1'b1);
        run_frames(2'd3, 8'h5A, 2, 1, 1'b1, 1'b1);

        // Asynchronous reset after beat 6, then no activity until a new start
        n_xfer = 0;
        mode_i = 2'd1;
        start_i = 1'b1;
        push_frame(2'd1, 8'h00, -1);
        tready_i = 1'b0;
        cycle();
        start_i = 1'b0;
        tready_i = 1'b1;
        for (int c = 0; c < 40 && n_xfer < 6; c++) cycle();
        chk("beats_before_reset", 32'(n_xfer), 32'd6);
        arst_i = 1'b1;
        #1;
        chk("rst_outputs", 32'({tdata_o, tvalid_o, tuser_o, tlast_o, busy_o}), 32'd0);
        chk("rst_cnt", 32'(frame_cnt_o), 32'd0);
        exp_q.delete();
        exp_cnt = '0;
        presented = 1'b0;
        prev_stall = 1'b0;
        idle_run = 0;
        cycle();
        arst_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("no_start_valid", 32'(tvalid_o), 32'd0);
        end
        run_frames(2'd0, 8'h00, 0, 1, 1'b0, 1'b0);
        chk("restart_first", 32'(first_data), 32'd0);

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            int nfr;
            nfr = int'($urandom_range(1, 2));
            run_frames(2'($urandom), D'($urandom), 2, nfr, 1'($urandom), (nfr == 1) && ($urandom % 2 == 1));
        end

        // Counter wrap: preload 0xFFFF, one frame must bring it to 0
        force dut.frame_cnt_o = 16'hFFFF;
        repeat (2) cycle();
        release dut.frame_cnt_o;
        cycle();
        exp_cnt = 16'hFFFF;
        chk("cnt_preload", 32'(frame_cnt_o), 32'h0000FFFF);
        run_frames(2'd2, 8'h00, 0, 1, 1'b0, 1'b0);
        chk("cnt_wrap", 32'(frame_cnt_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_axis_tx.md
FRAME_AXIS_TX -- requirements
Module: frame_axis_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 800, meaning pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 600, meaning lines per frame.
REQ-003 SHALL have parameter BIT_DATA_O, default 8, meaning pixel width in bits.
REQ-004 SHALL have parameter H_GAP, default 4, meaning idle cycles inserted between lines (0 allowed).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port arst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port start_i, input, 1 bit: frame request, sampled in IDLE only.
REQ-008 SHALL have port cont_i, input, 1 bit: continuous mode, sampled at frame end.
REQ-009 SHALL have port mode_i, input, 2 bits: pattern select.
REQ-010 SHALL have port const_i, input, BIT_DATA_O bits: constant pixel value for mode 3.
REQ-011 SHALL have port tready_i, input, 1 bit: sink ready.
REQ-012 SHALL have port tdata_o, output, BIT_DATA_O bits: pixel data.
REQ-013 SHALL have port tvalid_o, output, 1 bit: data valid.
REQ-014 SHALL have port tlast_o, output, 1 bit: last pixel of frame.
REQ-015 SHALL have port tuser_o, output, 1 bit: first pixel of frame.
REQ-016 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-017 SHALL have port frame_cnt_o, output, 16 bits: completed-frame count, wraps 0xFFFF->0.

Function
REQ-018 SHALL implement FSM states IDLE, ACTIVE, GAP.
REQ-019 IDLE: start_i=1 -> ACTIVE next cycle; x=0, y=0; latch mode_i and const_i. start_i SHALL be ignored outside IDLE.
REQ-020 A beat SHALL transfer only on a cycle where tvalid_o=1 and tready_i=1.
REQ-021 tvalid_o SHALL be 1 exactly in ACTIVE; once high, tvalid_o and tdata_o SHALL hold until the beat transfers.
REQ-022 On each transfer, x SHALL increment. At x=WIDTH-1: x->0, y->y+1.
REQ-023 After line end (not last line): H_GAP>0 -> GAP for exactly H_GAP cycles, then ACTIVE. H_GAP=0 -> remain in ACTIVE.
REQ-024 At transfer of (WIDTH-1, HEIGHT-1), frame_cnt_o SHALL increment. Then:
  - cont_i=0 -> IDLE.
  - cont_i=1 -> ACTIVE of next frame on the following cycle, with x=y=0, mode_i/const_i re-latched, no gap inserted.
REQ-025 tdata_o SHALL be, truncated to BIT_DATA_O bits:
  - mode 0: x
  - mode 1: y
  - mode 2: x+y (modulo 2^BIT_DATA_O)
  - mode 3: latched const.
REQ-026 tdata_o SHALL be 0 whenever tvalid_o=0.
REQ-027 tuser_o SHALL be 1 iff tvalid_o=1 and (x,y)=(0,0); tlast_o SHALL be 1 iff tvalid_o=1 and (x,y)=(WIDTH-1,HEIGHT-1).
REQ-028 Counter widths: x SHALL be $clog2(WIDTH) bits and y SHALL be $clog2(HEIGHT) bits; neither SHALL exceed its terminal value.
REQ-029 The GAP counter SHALL be reloaded on each GAP entry; tready_i SHALL have no effect in GAP or IDLE.
REQ-030 The output stream SHALL be directly consumable by the team's ROI cropper with the same WIDTH/HEIGHT.

Reset
REQ-031 arst_i=1 SHALL immediately force: state IDLE; x, y, gap counter, latched mode/const, frame_cnt_o all 0; tvalid_o, tlast_o, tuser_o, busy_o, tdata_o all 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no further beats; the next frame SHALL start from (0,0) only after a new start_i.

Verification (WIDTH=4, HEIGHT=3, H_GAP=2, BIT_DATA_O=8)
REQ-033 start_i pulse, mode 2, tready_i=1, cont_i=0 -> 12 beats with data 0,1,2,3 / 1,2,3,4 / 2,3,4,5; exactly 2 idle cycles between lines; tuser_o on beat 1, tlast_o on beat 12; frame_cnt_o=1; IDLE after.
REQ-034 mode 3, const_i=0xA5, tready_i toggling 1/0 each cycle -> all 12 beats 0xA5; tvalid_o never drops while stalled; exactly 12 transfers.
REQ-035 cont_i=1, mode 0 -> second frame's tuser_o beat in the cycle right after the first frame's tlast_o transfer; frame_cnt_o=2 after two frames.
REQ-036 arst_i asserted after beat 6 -> outputs 0 same cycle; with no start_i, tvalid_o stays 0; new start_i -> first beat at (0,0) with tuser_o=1.
REQ-037 start_i held high during ACTIVE, mode_i changed mid-frame -> no restart and pattern unchanged until the frame ends.
REQ-038 frame_cnt_o preset via 65535 frames (or forced) -> the next frame end wraps it to 0.
